// File: rtl/fabric_config_loader.sv
// Config-chain loader: clears a tile's shift chain, then
// serialises bitstream words into it LSB first.
module fabric_config_loader #(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 36,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_data,
  output logic                  config_enable,
  output logic                  config_nreset,
  output logic                  busy,
  output logic                  done
);

  localparam int BCW = $clog2(CHAIN_LENGTH + 1);
  localparam int WBW = $clog2(WORD_WIDTH + 1);
  localparam int CCW = $clog2(CLEAR_CYCLES + 1);
  localparam int MW  = (BCW > WBW) ? BCW : WBW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CCW-1:0]        clr_q, clr_d;
  logic [BCW-1:0]        bit_count_q, bit_count_d;
  logic [WBW-1:0]        word_bits_q, word_bits_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [MW-1:0]         remain;
  logic [MW-1:0]         take;

  // Bits still owed to the chain, capped at one word.
  assign remain = MW'(CHAIN_LENGTH) - MW'(bit_count_q);
  assign take   = (remain < MW'(WORD_WIDTH)) ? remain
                                             : MW'(WORD_WIDTH);

  // Next-state logic; shreg is zeroed on leaving SHIFT so the
  // serial output is quiet outside SHIFT and truncated bits die.
  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    bit_count_d = bit_count_q;
    word_bits_d = word_bits_q;
    shreg_d     = shreg_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_CLEAR;
          clr_d       = '0;
          bit_count_d = '0;
        end
      end
      S_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == CCW'(CLEAR_CYCLES - 1))
          state_d = S_FETCH;
      end
      S_FETCH: begin
        if (word_valid) begin
          shreg_d     = word_data;
          word_bits_d = WBW'(take);
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d     = shreg_q >> 1;
        bit_count_d = bit_count_q + 1'b1;
        word_bits_d = word_bits_q - 1'b1;
        if (bit_count_q == BCW'(CHAIN_LENGTH - 1)) begin
          state_d = S_DONE;
          shreg_d = '0;
        end else if (word_bits_q == WBW'(1)) begin
          state_d = S_FETCH;
          shreg_d = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      clr_q       <= '0;
      bit_count_q <= '0;
      word_bits_q <= '0;
      shreg_q     <= '0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      bit_count_q <= bit_count_d;
      word_bits_q <= word_bits_d;
      shreg_q     <= shreg_d;
    end
  end

  assign word_ready    = (state_q == S_FETCH);
  assign config_enable = (state_q == S_SHIFT);
  assign config_nreset = (state_q != S_CLEAR);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign config_data   = shreg_q[0];

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader: default build
// plus two narrow builds for the parameter sweep.
module tb_fabric_config_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, wvalid;
  logic [31:0] wdata;
  logic        word_ready, config_data, config_enable;
  logic        config_nreset, busy, done;

  logic        start_s, wvalid_s;
  logic [7:0]  wdata_s;
  logic        r8, d8, e8, n8, b8, dn8;
  logic        r1, d1, e1, n1, b1, dn1;

  fabric_config_loader u_dut (
    .clock(clk), .reset(rst), .start(start),
    .word_data(wdata), .word_valid(wvalid),
    .word_ready(word_ready), .config_data(config_data),
    .config_enable(config_enable),
    .config_nreset(config_nreset),
    .busy(busy), .done(done)
  );

  fabric_config_loader #(
    .WORD_WIDTH(8), .CHAIN_LENGTH(8), .CLEAR_CYCLES(4)
  ) u_c8 (
    .clock(clk), .reset(rst), .start(start_s),
    .word_data(wdata_s), .word_valid(wvalid_s),
    .word_ready(r8), .config_data(d8),
    .config_enable(e8), .config_nreset(n8),
    .busy(b8), .done(dn8)
  );

  fabric_config_loader #(
    .WORD_WIDTH(8), .CHAIN_LENGTH(1), .CLEAR_CYCLES(4)
  ) u_c1 (
    .clock(clk), .reset(rst), .start(start_s),
    .word_data(wdata_s), .word_valid(wvalid_s),
    .word_ready(r1), .config_data(d1),
    .config_enable(e1), .config_nreset(n1),
    .busy(b1), .done(dn1)
  );

  logic [5:0] outs, outs8, outs1;
  assign outs  = {word_ready, config_data, config_enable,
                  config_nreset, busy, done};
  assign outs8 = {r8, d8, e8, n8, b8, dn8};
  assign outs1 = {r1, d1, e1, n1, b1, dn1};

  int checks = 0;
  int errors = 0;
  int cyc = 0, en_cnt = 0, hs_cnt = 0, done_cnt = 0, clr_cnt = 0;
  int en8 = 0, hs8 = 0, en1 = 0, hs1 = 0;
  logic [35:0] chain = '1;
  logic [7:0]  ch8 = '1;
  logic        ch1 = 1'b0;

  // Chain models and event counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (config_enable) en_cnt <= en_cnt + 1;
    if (word_ready && wvalid) hs_cnt <= hs_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (!config_nreset) clr_cnt <= clr_cnt + 1;
    if (!config_nreset) chain <= '0;
    else if (config_enable) chain <= {config_data, chain[35:1]};
    if (e8) en8 <= en8 + 1;
    if (r8 && wvalid_s) hs8 <= hs8 + 1;
    if (!n8) ch8 <= '0;
    else if (e8) ch8 <= {d8, ch8[7:1]};
    if (e1) en1 <= en1 + 1;
    if (r1 && wvalid_s) hs1 <= hs1 + 1;
    if (!n1) ch1 <= 1'b0;
    else if (e1) ch1 <= d1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                      input int stall, input bit poke,
                      output int lat);
    int ts, idx, left;
    bit hsnow, poked, got;
    idx = 0; left = stall; poked = 0; got = 0; lat = -1;
    wdata = w0; wvalid = (stall == 0); start = 1'b1;
    ts = cyc;
    tick;
    start = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (word_ready) begin
        if (left > 0) begin
          wvalid = 1'b0;
          chk("stall_quiet", {config_enable, busy}, 2'b01);
          left--;
        end else begin
          wvalid = 1'b1;
        end
      end
      start = poke && config_enable && !poked;
      if (start) poked = 1;
      hsnow = word_ready && wvalid;
      tick;
      start = 1'b0;
      if (hsnow) begin
        idx++;
        wdata = (idx == 1) ? w1 : 32'hBAD0BAD0;
      end
      if (done) begin
        got = 1;
        lat = cyc - ts;
      end
    end
    chk("done_seen", got, 1);
  endtask

  initial begin
    int ts, lat, e0, d0, c0, h0, l8, l1;
    logic [31:0] w;
    logic [3:0]  wa;

    rst = 1'b1; start = 1'b0; wvalid = 1'b0; wdata = '0;
    start_s = 1'b0; wvalid_s = 1'b0; wdata_s = '0;
    #12;
    chk("reset_outs", outs, 6'b000100);
    chk("reset_sweep", {outs8, outs1}, 12'b000100_000100);
    rst = 1'b0;
    tick;
    wvalid = 1'b1; wdata = 32'hDEADBEEF;
    tick;
    chk("idle_ignores_valid", outs, 6'b000100);

    // Basic load, cycle by cycle.
    e0 = en_cnt; d0 = done_cnt; c0 = clr_cnt;
    w = 32'hDEADBEEF; wa = 4'hA;
    start = 1'b1; ts = cyc;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("clear", {config_nreset, config_enable, busy, word_ready},
          4'b0010);
      tick;
    end
    chk("fetch1", outs, 6'b100110);
    tick;
    wdata = 32'h0000000A;
    for (int i = 0; i < 32; i++) begin
      chk("shift1", {config_enable, config_data, word_ready},
          {1'b1, w[i], 1'b0});
      tick;
    end
    chk("bubble", outs, 6'b100110);
    tick;
    wdata = 32'hBAD0BAD0;
    for (int i = 0; i < 4; i++) begin
      chk("shift2", {config_enable, config_data}, {1'b1, wa[i]});
      tick;
    end
    chk("done_pulse", outs, 6'b000111);
    chk("latency_basic", cyc - ts, 43);
    tick;
    chk("idle_after", outs, 6'b000100);
    chk("chain_basic", chain, {4'hA, 32'hDEADBEEF});
    chk("en_total", en_cnt - e0, 36);
    chk("clr_total", clr_cnt - c0, 4);
    chk("done_once", done_cnt - d0, 1);

    // Truncated final word.
    h0 = hs_cnt;
    load(32'h01234567, 32'hFFFFFFF5, 0, 0, lat);
    chk("latency_trunc", lat, 43);
    tick; tick; tick;
    chk("trunc_words", hs_cnt - h0, 2);
    chk("chain_trunc", chain, {4'h5, 32'h01234567});

    // Source stalls in FETCH.
    e0 = en_cnt;
    load(32'hCAFEF00D, 32'h00000003, 10, 0, lat);
    chk("latency_stall", lat, 53);
    chk("en_stall", en_cnt - e0, 36);
    chk("chain_stall", chain, {4'h3, 32'hCAFEF00D});
    tick;

    // Start pulsed during SHIFT.
    d0 = done_cnt;
    load(32'h55AA55AA, 32'h00000009, 0, 1, lat);
    chk("latency_poke", lat, 43);
    tick; tick; tick;
    chk("poke_idle", outs, 6'b000100);
    chk("poke_done_once", done_cnt - d0, 1);
    chk("chain_poke", chain, {4'h9, 32'h55AA55AA});

    // Reset mid-SHIFT, then a clean reload.
    wvalid = 1'b1; wdata = 32'hFFFFFFFF; start = 1'b1;
    tick;
    start = 1'b0;
    e0 = en_cnt;
    for (int i = 0; i < 100 && (en_cnt - e0) < 10; i++) tick;
    chk("reached_10", en_cnt - e0, 10);
    #2 rst = 1'b1;
    #1 chk("reset_async", outs, 6'b000100);
    tick;
    rst = 1'b0;
    tick;
    c0 = clr_cnt; e0 = en_cnt;
    load(32'h12345678, 32'h0000000C, 0, 0, lat);
    chk("latency_reload", lat, 43);
    chk("clr_reload", clr_cnt - c0, 4);
    chk("en_reload", en_cnt - e0, 36);
    chk("chain_reload", chain, {4'hC, 32'h12345678});
    wvalid = 1'b0;
    tick;

    // Parameter sweep: 8-bit words, chains of 8 and 1.
    l8 = -1; l1 = -1;
    e0 = en8; h0 = hs8; c0 = en1; d0 = hs1;
    wdata_s = 8'hA5; wvalid_s = 1'b1; start_s = 1'b1;
    ts = cyc;
    tick;
    start_s = 1'b0;
    for (int i = 0; i < 60 && (l8 < 0 || l1 < 0); i++) begin
      if (dn8 && l8 < 0) l8 = cyc - ts;
      if (dn1 && l1 < 0) l1 = cyc - ts;
      if (l8 < 0 || l1 < 0) tick;
    end
    tick; tick; tick;
    chk("latency_c8", l8, 14);
    chk("latency_c1", l1, 7);
    chk("words_c8", hs8 - h0, 1);
    chk("words_c1", hs1 - d0, 1);
    chk("en_c8", en8 - e0, 8);
    chk("en_c1", en1 - c0, 1);
    chk("chain_c8", ch8, 8'hA5);
    chk("chain_c1", ch1, 1'b1);
    chk("sweep_idle", {outs8, outs1}, 12'b000100_000100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fabric_config_loader.md
# fabric_config_loader

Sequencer that loads a tile's configuration shift chain from a word-wide bitstream source. It accepts configuration words over a valid/ready handshake. It first clears the chain through its `config_nreset` input, then serialises exactly `CHAIN_LENGTH` bits into the chain, LSB first, qualified by `config_enable`. It sits between the bitstream port (host or boot ROM reader) and the head of a tile's config chain, e.g. an IO tile with a 36-bit chain.

## Interface
Parameters:
- `WORD_WIDTH`, 32: width of incoming bitstream words.
- `CHAIN_LENGTH`, 36: number of config flops in the target chain; must be ≥ 1.
- `CLEAR_CYCLES`, 4: cycles `config_nreset` is held low at load start; must be ≥ 1.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a load; sampled only in IDLE.
- `word_data`, in, `WORD_WIDTH`: bitstream word; bit 0 is shifted first.
- `word_valid`, in, 1: `word_data` valid.
- `word_ready`, out, 1: loader accepts the word this cycle.
- `config_data`, out, 1: serial data to the chain head (`config_in` of the chain).
- `config_enable`, out, 1: chain shift enable.
- `config_nreset`, out, 1: chain reset, active-low.
- `busy`, out, 1: a load is in progress (state ≠ IDLE).
- `done`, out, 1: one-cycle pulse when the last chain bit has been shifted.

## Operation
- States: IDLE, CLEAR, FETCH, SHIFT, DONE.
- IDLE:
  - `start`=1 → CLEAR; clear counter := 0; bit_count := 0.
  - `word_valid` is ignored.
- CLEAR:
  - `config_nreset`=0 and `config_enable`=0.
  - After `CLEAR_CYCLES` cycles in CLEAR → FETCH.
- FETCH:
  - `word_ready`=1.
  - On `word_valid`&&`word_ready`: shreg := `word_data`; word_bits := min(`WORD_WIDTH`, `CHAIN_LENGTH`−bit_count); → SHIFT.
  - Without `word_valid`, stays in FETCH indefinitely with `config_enable`=0.
- SHIFT:
  - `config_enable`=1 and `config_data`=shreg[0] each cycle.
  - Each cycle: shreg >>= 1; bit_count++; word_bits−−.
  - When bit_count reaches `CHAIN_LENGTH` → DONE.
  - Otherwise, when word_bits reaches 0 → FETCH.
- DONE: `done`=1 for exactly one cycle → IDLE.
- Upper bits of the final word beyond `CHAIN_LENGTH` are discarded and never shifted.
- Number of words consumed per load = ceil(`CHAIN_LENGTH`/`WORD_WIDTH`); no extra word is ever accepted.
- `start` outside IDLE is ignored; there is no restart mid-load.
- Widths:
  - bit_count is $clog2(`CHAIN_LENGTH`+1) bits.
  - word_bits is $clog2(`WORD_WIDTH`+1) bits.
  - The min() is computed at full width without truncation.
- Output decode:
  - `word_ready`, `config_enable` and `config_nreset` are decoded from the registered state only, with no combinational path from inputs.
  - `config_data` comes directly from the shreg[0] flop.
  - Outside SHIFT, `config_data`=0.

## Timing
- Reset values (asynchronous):
  - state=IDLE.
  - `word_ready`=0, `config_data`=0, `config_enable`=0, `config_nreset`=1, `busy`=0, `done`=0.
  - All counters and shreg = 0.
- `start` sampled at cycle T gives `busy`=1 and `config_nreset`=0 from T+1 through T+`CLEAR_CYCLES`.
- FETCH is entered at T+`CLEAR_CYCLES`+1.
- Word handshake in cycle F: first `config_enable` cycle is F+1. A word of k bits yields exactly k consecutive enable cycles, F+1..F+k.
- The next FETCH cycle is F+k+1. There is one bubble cycle per word, with `config_enable`=0 in FETCH.
- Minimum load latency from `start` to `done`: `CLEAR_CYCLES` + `CHAIN_LENGTH` + ceil(`CHAIN_LENGTH`/`WORD_WIDTH`) + 1 cycles.
- `done` is asserted in the cycle after the last enable cycle. `busy` is 1 in that cycle and 0 in the following one.
- `reset` asserted mid-load:
  - All outputs return to reset values immediately.
  - A partially shifted chain is left as is; the next load clears it via CLEAR.

## Test plan
- **Basic load** (defaults): `start`, then words 0xDEADBEEF and 0x0000000A presented with `word_valid` held high. Required response:
  - 4 cycles with `config_nreset`=0.
  - 32 enable cycles shifting 0xDEADBEEF LSB first, 1 bubble, then 4 enable cycles shifting bits 0,1,0,1.
  - `done` pulse one cycle later; 36 enable cycles in total.
  - A 36-bit chain model reads {4'hA, 32'hDEADBEEF}.
- **Truncation**: second word 0xFFFFFFF5. Only bits 0101 are shifted and the chain's upper 4 bits read 4'h5. `word_ready` never reasserts after the second handshake.
- **Stalled source**: `word_valid` low for 10 cycles in FETCH. Required response: `config_enable`=0 throughout, `busy`=1, bit_count unchanged; the load then completes normally.
- **Start while busy**: pulse `start` during SHIFT. No effect; exactly one `done` pulse occurs.
- **Reset mid-SHIFT**: assert `reset` after 10 enable cycles. Outputs go to reset values in the same cycle. A subsequent full load produces the correct chain contents, starting with 4 CLEAR cycles.
- **Parameter sweep**: `WORD_WIDTH`=8, `CHAIN_LENGTH`=8 and `CHAIN_LENGTH`=1. Required response: exactly 1 word is accepted, with 8 and 1 enable cycles respectively, and latency matches the formula.
